// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: instruction-memory side and decode-side handshake.
// master = fetch sequencer, slave = memory/decode environment.
interface fetch_sequencer_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        halted_o;
  logic        fault_o;

  modport master (
    output imem_addr, instr_o, pc_o, valid_o, halted_o, fault_o,
    input  imem_instr, stall_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_addr, instr_o, pc_o, valid_o, halted_o, fault_o,
    output imem_instr, stall_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, pairs registered-read words with their PC,
// handles stall/redirect/halt. Define FETCH_BOUNDS_EN to fault on fetches past MEM_BYTES.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned MEM_BYTES = 64
) (
  input logic               clk,
  input logic               rst_n,
  fetch_sequencer_if.master bus
);
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state;
  logic [31:0] fetch_pc, inflight_pc, hold_instr;
  logic        inflight_v, hold_v, fault;
  logic        valid, accept, halt_hit, oob, issue_ok;
  logic [31:0] instr;

  assign valid    = inflight_v & (state == ST_RUN);
  assign instr    = hold_v ? hold_instr : bus.imem_instr;
  assign accept   = valid & ~bus.stall_i;
  assign halt_hit = accept & (instr == HALT_WORD);
  // widened so a PC near the top of the address space cannot wrap past the limit
  assign oob      = ({1'b0, fetch_pc} + 33'd3) >= 33'(MEM_BYTES);

`ifdef FETCH_BOUNDS_EN
  assign issue_ok    = ~oob;
  assign bus.fault_o = fault;
`else
  logic unused_oob;
  assign unused_oob  = oob;
  assign issue_ok    = 1'b1;
  assign bus.fault_o = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^bus.redirect_pc_i[1:0];

  assign bus.imem_addr = fetch_pc;
  assign bus.pc_o      = inflight_pc;
  assign bus.valid_o   = valid;
  assign bus.instr_o   = valid ? instr : 32'h0;
  assign bus.halted_o  = (state == ST_HALT) & ~fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      fetch_pc    <= RESET_PC;
      inflight_pc <= 32'h0;
      inflight_v  <= 1'b0;
      hold_instr  <= 32'h0;
      hold_v      <= 1'b0;
      fault       <= 1'b0;
    end else if (bus.redirect_i) begin
      fetch_pc   <= {bus.redirect_pc_i[31:2], 2'b00};
      inflight_v <= 1'b0;
      hold_v     <= 1'b0;
      state      <= ST_RUN;
      fault      <= 1'b0;
    end else if (state != ST_HALT) begin
      if (halt_hit) begin
        state      <= ST_HALT;
        inflight_v <= 1'b0;
        hold_v     <= 1'b0;
      end else if (state == ST_RUN && bus.stall_i) begin
        // memory moves on to fetch_pc, so park the word decode has not taken yet
        if (!hold_v && inflight_v) begin
          hold_instr <= bus.imem_instr;
          hold_v     <= 1'b1;
        end
      end else if (!issue_ok) begin
        inflight_v <= 1'b0;
        hold_v     <= 1'b0;
        state      <= ST_HALT;
        fault      <= 1'b1;
      end else begin
        inflight_pc <= fetch_pc;
        inflight_v  <= 1'b1;
        fetch_pc    <= fetch_pc + 32'd4;
        hold_v      <= 1'b0;
        state       <= ST_RUN;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: stream-level reference model plus directed literals.
module tb_fetch_sequencer;
`ifdef FETCH_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  localparam int unsigned MEMB  = 16;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_PC(32'h0), .HALT_WORD(HALTW), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  bit          halt_en = 1'b0;
  logic [31:0] halt_addr = 32'h0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] v;
    if (halt_en && a == halt_addr) return HALTW;
    v = a * 32'h9E37_79B1 + 32'h0123_4567;
    if (v == HALTW) v = 32'h0;
    return v;
  endfunction

  // synchronous instruction memory, one-cycle registered read
  always @(posedge clk) bus.imem_instr <= memword(bus.imem_addr);

  // Model: which word decode should see next, and where fetch is parked.
  typedef enum {M_WAIT, M_STREAM, M_HALT, M_FAULT} mode_t;
  mode_t       mode = M_WAIT;
  bit          boot = 1'b1;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] frozen = 32'h0;

  function automatic bit oob(input logic [31:0] a);
    return BOUNDS && (({1'b0, a} + 33'd3) >= 33'(MEMB));
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit d, input logic [31:0] p);
    if (!r) begin
      mode = M_WAIT; boot = 1'b1; exp_pc = 32'h0;
    end else if (d) begin
      mode = M_WAIT; boot = 1'b0; exp_pc = {p[31:2], 2'b00};
    end else if (mode == M_WAIT) begin
      if (boot || !s) begin
        boot = 1'b0;
        if (oob(exp_pc)) begin mode = M_FAULT; frozen = exp_pc; end
        else mode = M_STREAM;
      end
    end else if (mode == M_STREAM && !s) begin
      if (memword(exp_pc) == HALTW) begin mode = M_HALT; frozen = exp_pc + 32'd4; end
      else if (oob(exp_pc + 32'd4)) begin mode = M_FAULT; frozen = exp_pc + 32'd4; end
      else exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit          ev;
    logic [31:0] eaddr;
    ev    = (mode == M_STREAM);
    eaddr = (mode == M_WAIT) ? exp_pc : (mode == M_STREAM) ? exp_pc + 32'd4 : frozen;
    chk("valid_o", 32'(bus.valid_o), 32'(ev));
    chk("halted_o", 32'(bus.halted_o), 32'(mode == M_HALT));
    chk("fault_o", 32'(bus.fault_o), 32'(mode == M_FAULT));
    chk("imem_addr", bus.imem_addr, eaddr);
    if (ev) begin
      chk("pc_o", bus.pc_o, exp_pc);
      chk("instr_o", bus.instr_o, memword(exp_pc));
    end
  endtask

  task automatic step(input bit r, input bit s, input bit d, input logic [31:0] p);
    rst_n = r; bus.stall_i = s; bus.redirect_i = d; bus.redirect_pc_i = p;
    @(posedge clk);
    model_edge(r, s, d, p);
    @(negedge clk);
    compare();
  endtask

  initial begin
    bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;

    // reset state, then BOOT cycle
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("rst valid_o", 32'(bus.valid_o), 32'h0);
    chk("rst halted_o", 32'(bus.halted_o), 32'h0);
    chk("rst fault_o", 32'(bus.fault_o), 32'h0);
    chk("rst pc_o", bus.pc_o, 32'h0);
    chk("rst instr_o", bus.instr_o, 32'h0);
    chk("boot imem_addr", bus.imem_addr, 32'h0);

    step(1, 0, 0, 0);
    chk("w0 pc", bus.pc_o, 32'h0);
    chk("w0 instr", bus.instr_o, 32'h0123_4567);
    step(1, 0, 0, 0);
    chk("w1 pc", bus.pc_o, 32'h4);
    chk("w1 instr", bus.instr_o, 32'h7A01_2C2B);

    // three stalled cycles on pc 4
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0);
      chk("stall pc", bus.pc_o, 32'h4);
      chk("stall instr", bus.instr_o, 32'h7A01_2C2B);
      chk("stall imem_addr", bus.imem_addr, 32'h8);
    end
    step(1, 0, 0, 0);
    chk("release pc", bus.pc_o, 32'h8);
    chk("release valid", 32'(bus.valid_o), 32'h1);

    // redirect while streaming
    step(1, 0, 1, 32'h13);
    chk("redir bubble valid", 32'(bus.valid_o), 32'h0);
    chk("redir imem_addr", bus.imem_addr, 32'h10);
    step(1, 0, 0, 0);
`ifndef FETCH_BOUNDS_EN
    chk("redir pc", bus.pc_o, 32'h10);
    chk("redir valid", 32'(bus.valid_o), 32'h1);
`endif

    // redirect on top of a stall with a held word
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h13);
    chk("redir+hold bubble", 32'(bus.valid_o), 32'h0);
    chk("redir+hold imem_addr", bus.imem_addr, 32'h10);
    step(1, 0, 0, 0);
`ifndef FETCH_BOUNDS_EN
    chk("redir+hold pc", bus.pc_o, 32'h10);
`endif

    // halt word at 8
    halt_en = 1'b1; halt_addr = 32'h8;
    step(1, 0, 1, 32'h0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("halt word pc", bus.pc_o, 32'h8);
    chk("halt word instr", bus.instr_o, HALTW);
    step(1, 0, 0, 0);
    chk("halted_o", 32'(bus.halted_o), 32'h1);
    chk("halted valid", 32'(bus.valid_o), 32'h0);
    step(1, 0, 0, 0); step(1, 1, 0, 0);
    chk("halted frozen addr", bus.imem_addr, 32'hC);
    step(1, 0, 1, 32'h0);
    chk("unhalt halted_o", 32'(bus.halted_o), 32'h0);
    step(1, 0, 0, 0);
    chk("unhalt pc", bus.pc_o, 32'h0);
    chk("unhalt valid", 32'(bus.valid_o), 32'h1);
    halt_en = 1'b0;

`ifdef FETCH_BOUNDS_EN
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("bounds pc", bus.pc_o, 32'(k * 4));
      chk("bounds valid", 32'(bus.valid_o), 32'h1);
      step(1, 0, 0, 0);
    end
    chk("bounds fault_o", 32'(bus.fault_o), 32'h1);
    chk("bounds valid off", 32'(bus.valid_o), 32'h0);
    chk("bounds halted_o", 32'(bus.halted_o), 32'h0);
    step(0, 0, 0, 0);
    chk("bounds reset fault_o", 32'(bus.fault_o), 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, s, d;
      logic [31:0] p;
      r = ($urandom_range(0, 79) != 0);
      if (!r) begin
        halt_en = ($urandom_range(0, 1) == 1);
        halt_addr = 32'($urandom_range(0, 15)) * 32'd4;
      end
      s = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 11) == 0);
      p = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : 32'($urandom_range(0, 63));
      step(r, s, d, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
